// File: rtl/circ_ptr_ctrl.sv
// Write/read base pointers, lane enables and occupancy status
// for a SIZE-entry circular buffer fed in bursts of 1..4 entries.
module circ_ptr_ctrl #(
    parameter int SIZE = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_req,
    input  logic [2:0]                   wr_cnt,
    input  logic                         rd_req,
    input  logic [2:0]                   rd_cnt,
    output logic [$clog2(SIZE)-1:0]      wr_ptr,
    output logic [$clog2(SIZE)-1:0]      rd_ptr,
    output logic [3:0]                   wr_lane_en,
    output logic [3:0]                   rd_lane_en,
    output logic                         wr_ack,
    output logic                         rd_ack,
    output logic [$clog2(SIZE+1)-1:0]    count,
    output logic                         full,
    output logic                         empty,
    output logic                         ovf_err,
    output logic                         udf_err
);

    localparam int W  = $clog2(SIZE);
    localparam int CW = $clog2(SIZE+1);

    logic [CW-1:0] free;
    logic          wr_cnt_ok;
    logic          rd_cnt_ok;
    logic [W:0]    wr_sum;
    logic [W:0]    rd_sum;
    logic [W-1:0]  wr_ptr_next;
    logic [W-1:0]  rd_ptr_next;
    logic [CW-1:0] count_next;

    assign free      = CW'(SIZE) - count;
    assign wr_cnt_ok = (wr_cnt != 3'd0) && (wr_cnt <= 3'd4);
    assign rd_cnt_ok = (rd_cnt != 3'd0) && (rd_cnt <= 3'd4);

    // Both decisions use start-of-cycle count; reset masks the acks.
    assign wr_ack = rst_n && wr_req && wr_cnt_ok
                    && ((CW+1)'(wr_cnt) <= {1'b0, free});
    assign rd_ack = rst_n && rd_req && rd_cnt_ok
                    && ((CW+1)'(rd_cnt) <= {1'b0, count});

    always_comb begin
        wr_lane_en = 4'b0000;
        rd_lane_en = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            wr_lane_en[i] = wr_ack && (3'(i) < wr_cnt);
            rd_lane_en[i] = rd_ack && (3'(i) < rd_cnt);
        end
    end

    // Sum kept one bit wider so the wrap compare sees the carry.
    assign wr_sum = {1'b0, wr_ptr} + (W+1)'(wr_cnt);
    assign rd_sum = {1'b0, rd_ptr} + (W+1)'(rd_cnt);

    always_comb begin
        wr_ptr_next = wr_sum[W-1:0];
        rd_ptr_next = rd_sum[W-1:0];
        if (wr_sum >= (W+1)'(SIZE)) begin
            wr_ptr_next = W'(wr_sum - (W+1)'(SIZE));
        end
        if (rd_sum >= (W+1)'(SIZE)) begin
            rd_ptr_next = W'(rd_sum - (W+1)'(SIZE));
        end
    end

    always_comb begin
        count_next = count;
        if (wr_ack) begin
            count_next = count_next + CW'(wr_cnt);
        end
        if (rd_ack) begin
            count_next = count_next - CW'(rd_cnt);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ovf_err <= 1'b0;
            udf_err <= 1'b0;
        end else begin
            if (wr_ack) begin
                wr_ptr <= wr_ptr_next;
            end
            if (rd_ack) begin
                rd_ptr <= rd_ptr_next;
            end
            count <= count_next;
            if (wr_req && !wr_ack) begin
                ovf_err <= 1'b1;
            end
            if (rd_req && !rd_ack) begin
                udf_err <= 1'b1;
            end
        end
    end

    assign full  = (count == CW'(SIZE));
    assign empty = (count == '0);

endmodule

// File: tb/tb_circ_ptr_ctrl.sv
// Directed vectors for circ_ptr_ctrl (SIZE=16) with a queue-based
// scoreboard; the monitor compares at the falling clock edge.
module tb_circ_ptr_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_req = 1'b0;
    logic [2:0] wr_cnt = 3'd0;
    logic       rd_req = 1'b0;
    logic [2:0] rd_cnt = 3'd0;
    logic [3:0] wr_ptr;
    logic [3:0] rd_ptr;
    logic [3:0] wr_lane_en;
    logic [3:0] rd_lane_en;
    logic       wr_ack;
    logic       rd_ack;
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic       ovf_err;
    logic       udf_err;

    typedef struct {
        int         id;
        logic       wa;
        logic       ra;
        logic [3:0] wl;
        logic [3:0] rl;
        logic [3:0] wp;
        logic [3:0] rp;
        logic [4:0] c;
        logic       o;
        logic       u;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   vid = 0;

    circ_ptr_ctrl #(.SIZE(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_req(wr_req), .wr_cnt(wr_cnt),
        .rd_req(rd_req), .rd_cnt(rd_cnt),
        .wr_ptr(wr_ptr), .rd_ptr(rd_ptr),
        .wr_lane_en(wr_lane_en), .rd_lane_en(rd_lane_en),
        .wr_ack(wr_ack), .rd_ack(rd_ack),
        .count(count), .full(full), .empty(empty),
        .ovf_err(ovf_err), .udf_err(udf_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input int id, input string name,
                       input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL v%0d %s actual=%0d required=%0d",
                     id, name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.id, "wr_ack", int'(wr_ack), int'(e.wa));
            chk(e.id, "rd_ack", int'(rd_ack), int'(e.ra));
            chk(e.id, "wr_lane_en", int'(wr_lane_en), int'(e.wl));
            chk(e.id, "rd_lane_en", int'(rd_lane_en), int'(e.rl));
            chk(e.id, "wr_ptr", int'(wr_ptr), int'(e.wp));
            chk(e.id, "rd_ptr", int'(rd_ptr), int'(e.rp));
            chk(e.id, "count", int'(count), int'(e.c));
            chk(e.id, "full", int'(full), int'(e.c == 5'd16));
            chk(e.id, "empty", int'(empty), int'(e.c == 5'd0));
            chk(e.id, "ovf_err", int'(ovf_err), int'(e.o));
            chk(e.id, "udf_err", int'(udf_err), int'(e.u));
        end
    end

    // One cycle: drive request, optionally pulse reset mid-cycle,
    // and queue the outputs expected before the next rising edge.
    task automatic vec(input bit wq, input int wc,
                       input bit rq, input int rc,
                       input bit wa, input bit ra,
                       input int wl, input int rl,
                       input int wp, input int rp, input int c,
                       input bit o, input bit u, input bit rs);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        wr_req = wq;
        wr_cnt = 3'(wc);
        rd_req = rq;
        rd_cnt = 3'(rc);
        if (rs) begin
            #1 rst_n = 1'b0;
        end
        e.id = vid;
        e.wa = wa;
        e.ra = ra;
        e.wl = 4'(wl);
        e.rl = 4'(rl);
        e.wp = 4'(wp);
        e.rp = 4'(rp);
        e.c  = 5'(c);
        e.o  = o;
        e.u  = u;
        q.push_back(e);
        vid++;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        //  wq wc rq rc  wa ra wl  rl  wp rp  c  o u rs
        vec(0, 0, 0, 0,  0, 0, 0,  0,  0, 0,  0, 0,0,0);
        vec(1, 4, 0, 0,  1, 0, 15, 0,  0, 0,  0, 0,0,0);
        vec(1, 4, 0, 0,  1, 0, 15, 0,  4, 0,  4, 0,0,0);
        vec(1, 4, 0, 0,  1, 0, 15, 0,  8, 0,  8, 0,0,0);
        vec(1, 4, 0, 0,  1, 0, 15, 0, 12, 0, 12, 0,0,0);
        vec(1, 1, 0, 0,  0, 0, 0,  0,  0, 0, 16, 0,0,0);
        vec(0, 0, 0, 0,  0, 0, 0,  0,  0, 0, 16, 1,0,0);
        vec(0, 0, 1, 4,  0, 1, 0, 15,  0, 0, 16, 1,0,0);
        vec(0, 0, 1, 4,  0, 1, 0, 15,  0, 4, 12, 1,0,0);
        vec(0, 0, 1, 4,  0, 1, 0, 15,  0, 8,  8, 1,0,0);
        vec(0, 0, 1, 1,  0, 1, 0,  1,  0,12,  4, 1,0,0);
        vec(0, 0, 1, 4,  0, 0, 0,  0,  0,13,  3, 1,0,0);
        vec(0, 0, 1, 3,  0, 1, 0,  7,  0,13,  3, 1,1,0);
        vec(1, 4, 0, 0,  1, 0, 15, 0,  0, 0,  0, 1,1,0);
        vec(1, 4, 1, 4,  1, 1, 15,15,  4, 0,  4, 1,1,0);
        vec(1, 4, 1, 4,  1, 1, 15,15,  8, 4,  4, 1,1,0);
        vec(1, 2, 1, 4,  1, 1, 3, 15, 12, 8,  4, 1,1,0);
        vec(0, 0, 1, 2,  0, 1, 0,  3, 14,12,  2, 1,1,0);
        vec(1, 3, 0, 0,  1, 0, 7,  0, 14,14,  0, 1,1,0);
        vec(0, 0, 1, 3,  0, 1, 0,  7,  1,14,  3, 1,1,0);
        vec(0, 0, 0, 0,  0, 0, 0,  0,  1, 1,  0, 1,1,0);
        vec(1, 2, 0, 0,  1, 0, 3,  0,  1, 1,  0, 1,1,0);
        vec(1, 4, 1, 2,  1, 1, 15, 3,  3, 1,  2, 1,1,0);
        vec(1, 5, 1, 0,  0, 0, 0,  0,  7, 3,  4, 1,1,0);
        vec(1, 4, 0, 0,  1, 0, 15, 0,  7, 3,  4, 1,1,0);
        vec(1, 4, 0, 0,  1, 0, 15, 0, 11, 3,  8, 1,1,0);
        vec(1, 4, 0, 0,  1, 0, 15, 0, 15, 3, 12, 1,1,0);
        vec(1, 2, 1, 2,  0, 1, 0,  3,  3, 3, 16, 1,1,0);
        vec(0, 0, 1, 4,  0, 1, 0, 15,  3, 5, 14, 1,1,0);
        vec(0, 0, 1, 1,  0, 1, 0,  1,  3, 9, 10, 1,1,0);
        vec(0, 0, 0, 0,  0, 0, 0,  0,  3,10,  9, 1,1,0);
        vec(1, 1, 1, 1,  0, 0, 0,  0,  0, 0,  0, 0,0,1);
        vec(0, 0, 0, 0,  0, 0, 0,  0,  0, 0,  0, 0,0,0);
        vec(1, 1, 0, 0,  1, 0, 1,  0,  0, 0,  0, 0,0,0);
        vec(0, 0, 0, 0,  0, 0, 0,  0,  1, 0,  1, 0,0,0);
        for (int i = 0; i < 10 && q.size() > 0; i++) begin
            @(posedge clk);
        end
        if (q.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain actual=%0d required=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/circ_ptr_ctrl.md
# circ_ptr_ctrl

Pointer and occupancy controller for the SIZE-entry circular buffer whose 4-wide lane addresses are expanded by the consecutive-index generator. Each cycle it accepts at most one write burst and one read burst of 1–4 entries. It advances the write and read base pointers modulo SIZE and drives the per-lane enables that qualify the generator's four addresses. It sits directly upstream of the two generator instances (write side and read side) and owns full/empty/count status for the buffer.

## Interface
- SIZE, 16, number of buffer entries; any integer ≥ 4, not required to be a power of two
- W, $clog2(SIZE), pointer width (derived, not overridden)
- CW, $clog2(SIZE+1), occupancy count width (derived)

- clk  in  1  rising-edge clock, the only clock
- rst_n  in  1  asynchronous, active-low reset
- wr_req  in  1  write burst request
- wr_cnt  in  3  entries in write burst, legal 1..4
- rd_req  in  1  read burst request
- rd_cnt  in  3  entries in read burst, legal 1..4
- wr_ptr  out  W  registered write base index, feeds write-side generator num_in
- rd_ptr  out  W  registered read base index, feeds read-side generator num_in
- wr_lane_en  out  4  combinational; bit i qualifies write lane i (address wr_ptr+i mod SIZE)
- rd_lane_en  out  4  combinational; bit i qualifies read lane i
- wr_ack  out  1  combinational; write burst accepted this cycle
- rd_ack  out  1  combinational; read burst accepted this cycle
- count  out  CW  registered occupancy, 0..SIZE
- full  out  1  count == SIZE
- empty  out  1  count == 0
- ovf_err  out  1  sticky; set on any rejected write request
- udf_err  out  1  sticky; set on any rejected read request

## Operation
- Free space: free = SIZE − count. Both decisions use the start-of-cycle count.
- Write accept: wr_ack = wr_req && 1 ≤ wr_cnt ≤ 4 && wr_cnt ≤ free. All-or-nothing; no partial bursts.
- Read accept: rd_ack = rd_req && 1 ≤ rd_cnt ≤ 4 && rd_cnt ≤ count. A same-cycle read cannot consume entries written that cycle. A same-cycle write cannot use space freed by that cycle's read.
- Lane enables: wr_lane_en[i] = wr_ack && (i < wr_cnt). rd_lane_en[i] = rd_ack && (i < rd_cnt). Otherwise 4'b0000.
- Pointer update on accept: ptr_next = (ptr + cnt ≥ SIZE) ? ptr + cnt − SIZE : ptr + cnt. Compute in W+1 bits, never truncate before the compare.
- Count update: count_next = count + (wr_ack ? wr_cnt : 0) − (rd_ack ? rd_cnt : 0). Simultaneous accepts net out in one cycle.
- Rejection: a request with an illegal cnt (0, 5–7) or an insufficient space/data condition is dropped. Pointers and count are unchanged, and the matching sticky error flag is set. Error flags clear only on reset.
- full and empty decode from registered count; no extra latency.

## Timing
- Reset (rst_n low, asynchronous): wr_ptr = 0, rd_ptr = 0, count = 0, ovf_err = 0, udf_err = 0. Hence empty = 1, full = 0.
- While in reset, wr_ack, rd_ack and all lane enables are 0 regardless of requests.
- Reset asserted mid-burst discards the burst; nothing is committed.
- wr_ack, rd_ack and lane enables are valid in the same cycle as the request; the memory writes/reads at that edge.
- Pointers, count, full, empty and error flags reflect an accept one cycle later (1-cycle latency).
- Back-to-back bursts every cycle are supported; sustained throughput is 4 writes + 4 reads per cycle.
- Wrap-around: pointer at SIZE−1 with cnt 4 → next pointer 3 (SIZE=16). Lane addresses wrap in the generator, not here.

## Test plan
- Reset, then write cnt=4 four times (SIZE=16) → wr_ptr 0→4→8→12→0, count 16, full=1, wr_lane_en=4'b1111 each cycle.
- Full buffer, write cnt=1 → wr_ack=0, wr_lane_en=0, ovf_err=1 next cycle, count stays 16.
- count=3, read cnt=4 → rejected, udf_err=1. Then read cnt=3 → rd_lane_en=4'b0111, count 0, empty=1.
- wr_ptr=14, count=0, write cnt=3 → wr_lane_en=4'b0111, wr_ptr=1 next cycle. Then read cnt=3 from rd_ptr=14 → rd_ptr=1.
- count=2, simultaneous write cnt=4 and read cnt=2 → both acked, count=4. Then count=16 with write cnt=2 and read cnt=2 → only read acked, count=14.
- Assert rst_n low asynchronously mid-cycle with count=9 and flags set → all outputs at reset values immediately, before the next clock edge.
